// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU slice.
//   loader_state_t : imem_loader FSM states
//   INSTR_WIDTH    : instruction word width in bits
package cpu_pkg;

  localparam int INSTR_WIDTH = 32;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory program loader.
// Accepts instruction words on a valid/ready stream and writes them to
// consecutive word indices starting at 0, holding the CPU in reset. After
// the word flagged in_last it keeps cpu_reset high for RESET_HOLD more
// cycles, then releases the CPU so it fetches from PC 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     input stream handshake
//   in_data, in_last      instruction word and end-of-program flag
//   start                 restart pulse, honoured in RUN or ERR only
//   im_we/im_addr/im_wdata  instruction-memory write port (word index)
//   cpu_reset             reset to the CPU, low only in RUN
//   load_done             high in RUN
//   word_count            words accepted in the current load
//   err_overflow          high in ERR (memory filled without in_last)
//   checksum              XOR of accepted words (IMEM_LOADER_CHECKSUM_EN only)
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to add the checksum output.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RESET_HOLD = 2   // 1..15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_data,
  input  logic                   in_last,
  input  logic                   start,
  output logic                   im_we,
  output logic [ADDR_WIDTH-1:0]  im_addr,
  output logic [INSTR_WIDTH-1:0] im_wdata,
  output logic                   cpu_reset,
  output logic                   load_done,
  output logic [ADDR_WIDTH:0]    word_count,
  output logic                   err_overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [INSTR_WIDTH-1:0] checksum
`endif
);

  localparam int unsigned       DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [3:0]        HOLD_END = 4'(RESET_HOLD - 1);

  loader_state_t state, state_nxt;
  logic [3:0]    hold_cnt;
  logic          xfer;
  logic          restart;

  // in_ready is only ever high in LOAD, so no extra state qualifier needed.
  assign xfer    = in_valid & in_ready;
  assign restart = start & ((state == RUN) | (state == ERR));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: begin
        if (xfer) begin
          if (in_last)                    state_nxt = HOLD;
          else if (word_count == LAST_IDX) state_nxt = ERR;
        end
      end
      HOLD: if (hold_cnt == HOLD_END) state_nxt = RUN;
      RUN:  if (start) state_nxt = LOAD;
      ERR:  if (start) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Output decode
  always_comb begin
    cpu_reset    = (state != RUN);
    load_done    = (state == RUN);
    err_overflow = (state == ERR);
  end

  // Datapath: write port, word counter, hold counter, registered ready.
  // in_ready follows the next state so it drops right after the last
  // accepted word and is low for the cycle following reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready   <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      word_count <= '0;
      hold_cnt   <= '0;
    end else begin
      in_ready <= (state_nxt == LOAD);
      im_we    <= xfer;
      hold_cnt <= (state == HOLD) ? hold_cnt + 4'd1 : 4'd0;
      if (xfer) begin
        im_addr    <= word_count[ADDR_WIDTH-1:0];
        im_wdata   <= in_data;
        word_count <= word_count + (ADDR_WIDTH+1)'(1);
      end else if (restart) begin
        word_count <= '0;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Folded at the transfer edge so it is current in the write cycle.
  always_ff @(posedge clk) begin
    if (reset || restart) checksum <= '0;
    else if (xfer)        checksum <= checksum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int AW    = 6;
  localparam int RH    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          start = 1'b0;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_reset;
  logic          load_done;
  logic [AW:0]   word_count;
  logic          err_overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference instruction memory, filled only by observed write pulses.
  logic [31:0] mem [DEPTH];
  int          wcnt[DEPTH] = '{default: 0};
  int          nwrites = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .RESET_HOLD(RH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .start(start), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata), .cpu_reset(cpu_reset),
    .load_done(load_done), .word_count(word_count), .err_overflow(err_overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (im_we) begin
      mem[im_addr]  = im_wdata;
      wcnt[im_addr] = wcnt[im_addr] + 1;
      nwrites       = nwrites + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Offer one word; ok=1 if it was accepted within TMO cycles.
  task automatic drive_word(input logic [31:0] d, input bit last, output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    ok = 1'b0;
    for (int t = 0; t < TMO; t++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_run(output int fall_cyc);
    fall_cyc = -1;
    for (int k = 0; k < 40; k++) begin
      if (!cpu_reset) begin
        fall_cyc = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({in_ready, im_we, im_addr, im_wdata, cpu_reset, load_done, word_count, err_overflow}
        !== {1'b0, 1'b0, {AW{1'b0}}, 32'd0, 1'b1, 1'b0, {(AW+1){1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%0d wd=%h crst=%b done=%b wc=%0d err=%b, want 0 0 0 0 1 0 0 0",
               in_ready, im_we, im_addr, im_wdata, cpu_reset, load_done, word_count, err_overflow);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
  endtask

  // 41-word stream, no gaps, then check memory and cpu_reset release timing.
  task automatic test_back_to_back;
    logic [31:0] prog[41];
    logic [31:0] cs = '0;
    int wbase[DEPTH];
    int base, lcyc, fcyc, bad;
    bit ok, allok = 1'b1;
    do_reset();
    base = nwrites;
    wbase = wcnt;
    for (int i = 0; i < 41; i++) begin
      prog[i] = $urandom;
      cs ^= prog[i];
      drive_word(prog[i], i == 40, ok);
      allok &= ok;
    end
    lcyc = cyc;
    checks++;
    if (!allok) begin errors++; $display("FAIL b2b_accept: a word was not accepted"); end
    checks++;
    if (im_we !== 1'b1 || im_addr !== AW'(40) || im_wdata !== prog[40]) begin
      errors++;
      $display("FAIL b2b_last_write: we=%b addr=%0d data=%h want 1 40 %h", im_we, im_addr, im_wdata, prog[40]);
    end
    checks++;
    if (in_ready !== 1'b0 || word_count !== (AW+1)'(41) || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL b2b_after_last: rdy=%b wc=%0d crst=%b want 0 41 1", in_ready, word_count, cpu_reset);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== cs) begin
      errors++;
      $display("FAIL b2b_checksum: got %h want %h", checksum, cs);
    end
`endif
    // Keep offering a word through HOLD/RUN; none may be accepted.
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
    wait_run(fcyc);
    checks++;
    if (fcyc - lcyc != RH || load_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release: fall-lastwrite=%0d done=%b want %0d 1", fcyc - lcyc, load_done, RH);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < 41; i++)
      if (mem[i] !== prog[i] || wcnt[i] - wbase[i] != 1) bad++;
    checks++;
    if (bad != 0 || nwrites - base != 41) begin
      errors++;
      $display("FAIL b2b_memory: bad_words=%0d writes=%0d want 0 41", bad, nwrites - base);
    end
  endtask

  task automatic test_gaps;
    logic [31:0] prog[10];
    int wbase[DEPTH];
    int base, bad;
    bit ok, allok = 1'b1;
    do_reset();
    base = nwrites;
    wbase = wcnt;
    for (int i = 0; i < 10; i++) begin
      prog[i] = $urandom;
      repeat ($urandom_range(0, 3)) tick();
      drive_word(prog[i], i == 9, ok);
      allok &= ok;
    end
    checks++;
    if (!allok || word_count !== (AW+1)'(10)) begin
      errors++;
      $display("FAIL gaps_count: accepted_all=%b wc=%0d want 1 10", allok, word_count);
    end
    repeat (3) tick();
    bad = 0;
    for (int i = 0; i < 10; i++)
      if (mem[i] !== prog[i] || wcnt[i] - wbase[i] != 1) bad++;
    checks++;
    if (bad != 0 || nwrites - base != 10) begin
      errors++;
      $display("FAIL gaps_memory: bad_words=%0d writes=%0d want 0 10", bad, nwrites - base);
    end
  endtask

  task automatic test_overflow;
    int base;
    bit ok, okbad = 1'b0;
    do_reset();
    base = nwrites;
    for (int i = 0; i <= DEPTH; i++) begin
      drive_word($urandom, 1'b0, ok);
      if (ok != (i < DEPTH)) okbad = 1'b1;
    end
    checks++;
    if (okbad) begin errors++; $display("FAIL ovf_accept: acceptance pattern wrong (want first %0d only)", DEPTH); end
    checks++;
    if (err_overflow !== 1'b1 || cpu_reset !== 1'b1 || in_ready !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flags: err=%b crst=%b rdy=%b done=%b want 1 1 0 0", err_overflow, cpu_reset, in_ready, load_done);
    end
    checks++;
    if (word_count !== (AW+1)'(DEPTH) || nwrites - base != DEPTH) begin
      errors++;
      $display("FAIL ovf_count: wc=%0d writes=%0d want %0d %0d", word_count, nwrites - base, DEPTH, DEPTH);
    end
    pulse_start();
    checks++;
    if (err_overflow !== 1'b0 || word_count !== '0 || cpu_reset !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_restart: err=%b wc=%0d crst=%b rdy=%b want 0 0 1 1", err_overflow, word_count, cpu_reset, in_ready);
    end
  endtask

  task automatic test_restart;
    logic [31:0] p5[5];
    logic [31:0] p3[3];
    int base, fcyc;
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      p5[i] = $urandom;
      drive_word(p5[i], i == 4, ok);
    end
    wait_run(fcyc);
    tick();
    pulse_start();
    checks++;
    if (load_done !== 1'b0 || cpu_reset !== 1'b1 || word_count !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_state: done=%b crst=%b wc=%0d rdy=%b want 0 1 0 1", load_done, cpu_reset, word_count, in_ready);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 32'd0) begin errors++; $display("FAIL restart_checksum: got %h want 0", checksum); end
`endif
    base = nwrites;
    p3[0] = $urandom;
    drive_word(p3[0], 1'b0, ok);
    // start during LOAD has no effect
    pulse_start();
    checks++;
    if (word_count !== (AW+1)'(1) || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_in_load: wc=%0d rdy=%b want 1 1", word_count, in_ready);
    end
    for (int i = 1; i < 3; i++) begin
      p3[i] = $urandom;
      drive_word(p3[i], i == 2, ok);
    end
    wait_run(fcyc);
    tick();
    checks++;
    if (mem[0] !== p3[0] || mem[1] !== p3[1] || mem[2] !== p3[2] || mem[3] !== p5[3]
        || nwrites - base != 3 || fcyc < 0) begin
      errors++;
      $display("FAIL restart_memory: m0..3=%h %h %h %h writes=%0d want %h %h %h %h 3",
               mem[0], mem[1], mem[2], mem[3], nwrites - base, p3[0], p3[1], p3[2], p5[3]);
    end
  endtask

  task automatic test_reset_midload;
    logic [31:0] prog[8];
    int fcyc, bad;
    bit ok;
    do_reset();
    for (int i = 0; i < 8; i++) prog[i] = $urandom;
    for (int i = 0; i < 5; i++) drive_word(prog[i], 1'b0, ok);
    do_reset();
    checks++;
    if ({in_ready, im_we, im_addr, im_wdata, cpu_reset, load_done, word_count, err_overflow}
        !== {1'b0, 1'b0, {AW{1'b0}}, 32'd0, 1'b1, 1'b0, {(AW+1){1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL midload_reset: rdy=%b we=%b addr=%0d wd=%h crst=%b done=%b wc=%0d err=%b, want 0 0 0 0 1 0 0 0",
               in_ready, im_we, im_addr, im_wdata, cpu_reset, load_done, word_count, err_overflow);
    end
    for (int i = 0; i < 8; i++) drive_word(prog[i], i == 7, ok);
    wait_run(fcyc);
    tick();
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem[i] !== prog[i]) bad++;
    checks++;
    if (bad != 0 || fcyc < 0) begin
      errors++;
      $display("FAIL midload_memory: bad_words=%0d released=%b want 0 1", bad, fcyc >= 0);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int fcyc;
    bit ok;
    do_reset();
    drive_word(32'h0000_0001, 1'b0, ok);
    drive_word(32'h0000_0003, 1'b0, ok);
    drive_word(32'hFFFF_FFFF, 1'b1, ok);
    checks++;
    if (checksum !== 32'hFFFF_FFFD) begin errors++; $display("FAIL checksum_value: got %h want fffffffd", checksum); end
    wait_run(fcyc);
    tick();
    checks++;
    if (checksum !== 32'hFFFF_FFFD) begin errors++; $display("FAIL checksum_hold: got %h want fffffffd", checksum); end
    pulse_start();
    checks++;
    if (checksum !== 32'd0) begin errors++; $display("FAIL checksum_clear: got %h want 0", checksum); end
  endtask
`endif

  initial begin
    repeat (2) tick();
    test_reset();
    test_back_to_back();
    test_gaps();
    test_overflow();
    test_restart();
    test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
